display_demux: RTL and testbench
================================

DISPLAY_DEMUX -- requirements
Module: display_demux

Interface
REQ-001 The block SHALL have parameter STALE_CYCLES, default 8, giving the cycles without a completed frame before stale asserts (range 4..255).
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port hex  input  7  seven-segment pattern {g,f,e,d,c,b,a}, active-low (0 = segment lit).
REQ-005 Port dsel  input  3  digit select, active-low: 110 = units, 101 = tens, 011 = hundreds; any other code = idle.
REQ-006 Port bin  output  10  last decoded value, unsigned binary.
REQ-007 Port valid  output  1  one-cycle pulse: bin updated this cycle.
REQ-008 Port err  output  1  one-cycle pulse: illegal segment pattern on an active digit.
REQ-009 Port stale  output  1  level: no complete frame within STALE_CYCLES cycles.

Function
REQ-010 hex and dsel SHALL be sampled on the clk rising edge; the driver changes them on the falling edge, so no input synchronizer is required.
REQ-011 Segment decode SHALL accept exactly: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other pattern is illegal.
REQ-012 The FSM SHALL have states WAIT_U, HAVE_U and HAVE_T, and reset to WAIT_U.
REQ-013 In every state, a legal units digit SHALL latch und and go to HAVE_U, so a units digit restarts the frame.
REQ-014 In HAVE_U, a legal tens digit SHALL latch dez and go to HAVE_T.
REQ-015 In HAVE_T, a legal hundreds digit SHALL go to WAIT_U; at that same edge bin SHALL load hundreds*100 + dez*10 + und and valid SHALL pulse high for one cycle.
REQ-016 Any other active digit (out of order) SHALL return the FSM to WAIT_U without touching bin, valid or err.
REQ-017 Idle dsel codes SHALL leave the state unchanged.
REQ-018 An illegal pattern on any active digit SHALL pulse err for one cycle at the sampling edge, return the FSM to WAIT_U and leave bin unchanged; err has priority over valid.
REQ-019 The product arithmetic SHALL be at least 10 bits wide; the maximum result is 999 and SHALL NOT truncate.
REQ-020 bin SHALL hold its value between valid pulses.
REQ-021 A stale counter SHALL clear on every valid pulse and otherwise increment, saturating at STALE_CYCLES.
REQ-022 stale SHALL be 1 exactly while the counter equals STALE_CYCLES, and SHALL fall on the edge that produces valid.
REQ-023 Back-to-back frames (U,T,H,U,T,H) SHALL give a valid pulse every third cycle with no lost frames.

Reset
REQ-024 While rst=1: state=WAIT_U, bin=0, valid=0, err=0, und=dez=0, stale counter=0, stale=0.
REQ-025 rst asserted mid-frame SHALL discard the partial digits; the first valid after release requires a full U,T,H sequence.

Configuration
REQ-026 With macro DISPLAY_DEMUX_CHANGE_ONLY_EN defined, valid SHALL pulse (and bin update) only when the new value differs from the current bin; an equal frame SHALL still clear the stale counter.
REQ-027 Without DISPLAY_DEMUX_CHANGE_ONLY_EN, every completed frame SHALL pulse valid, including repeats.

Verification
REQ-028 Frame U=1111000/110, T=0110000/101, H=0011001/011 -> bin=437, single valid pulse at the H edge, err=0.
REQ-029 Same frame of 437 repeated twice -> two valid pulses without the macro; one pulse with DISPLAY_DEMUX_CHANGE_ONLY_EN.
REQ-030 Units pattern 0111111 (dash) with dsel=110 -> err pulse, bin keeps its old value, next full frame of 000 -> bin=0 with valid.
REQ-031 Sequence U(5), H(2) with no tens -> no valid; then U(9),T(9),H(9) -> bin=999, valid.
REQ-032 dsel held at 111 for 8 cycles after reset (STALE_CYCLES=8) -> stale=1 at the 8th edge; next complete frame -> stale=0 on the valid edge.
REQ-033 rst pulse between T and H of frame 123 -> no valid for that frame; next full frame of 123 -> bin=123.

Source files
------------

// File: rtl/display_demux.sv
`default_nettype none
// ============================================================================
// Module      : display_demux
// Description : Recovers a 3-digit decimal value from a multiplexed,
//               active-low seven-segment display bus.  Digits arrive in
//               units -> tens -> hundreds order; a completed frame loads the
//               binary result and pulses valid.  Illegal segment patterns
//               pulse err, and stale flags a missing frame.
//               Optional macro DISPLAY_DEMUX_CHANGE_ONLY_EN: pulse valid only
//               when the decoded value differs from the current bin.
// Revision    : 1.0 - initial release
// ============================================================================
module display_demux #(
    parameter int STALE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] hex,
    input  logic [2:0] dsel,
    output logic [9:0] bin,
    output logic       valid,
    output logic       err,
    output logic       stale
);

    typedef enum logic [1:0] {
        WAIT_U = 2'd0,
        HAVE_U = 2'd1,
        HAVE_T = 2'd2
    } state_t;

    localparam logic [7:0] c_STALE_MAX = 8'(STALE_CYCLES);

    state_t     r_state;
    logic [3:0] r_und;
    logic [3:0] r_dez;
    logic [9:0] r_bin;
    logic       r_valid;
    logic       r_err;
    logic [7:0] r_stale_cnt;

    logic       w_is_u;
    logic       w_is_t;
    logic       w_is_h;
    logic       w_active;
    logic       w_legal;
    logic [3:0] w_digit;
    logic [9:0] w_sum;
    logic       w_frame_done;

    // Decode a segment pattern into {legal, digit}; anything not in the table is illegal
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: f_decode = {1'b1, 4'd0};
            7'b1111001: f_decode = {1'b1, 4'd1};
            7'b0100100: f_decode = {1'b1, 4'd2};
            7'b0110000: f_decode = {1'b1, 4'd3};
            7'b0011001: f_decode = {1'b1, 4'd4};
            7'b0010010: f_decode = {1'b1, 4'd5};
            7'b0000010: f_decode = {1'b1, 4'd6};
            7'b1111000: f_decode = {1'b1, 4'd7};
            7'b0000000: f_decode = {1'b1, 4'd8};
            7'b0010000: f_decode = {1'b1, 4'd9};
            default:    f_decode = {1'b0, 4'd0};
        endcase
    endfunction

    assign w_is_u   = (dsel == 3'b110);
    assign w_is_t   = (dsel == 3'b101);
    assign w_is_h   = (dsel == 3'b011);
    assign w_active = w_is_u | w_is_t | w_is_h;

    assign {w_legal, w_digit} = f_decode(hex);

    // Hundreds are used directly at the completing edge, so only units/tens are stored
    assign w_sum = 10'(w_digit) * 10'd100 + 10'(r_dez) * 10'd10 + 10'(r_und);

    assign w_frame_done = w_active & w_legal & w_is_h & (r_state == HAVE_T);

    // Frame-assembly FSM with registered bin/valid/err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_U;
            r_und   <= 4'd0;
            r_dez   <= 4'd0;
            r_bin   <= 10'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_active) begin
                if (!w_legal) begin
                    // Illegal pattern wins over everything, including a completing hundreds digit
                    r_err   <= 1'b1;
                    r_state <= WAIT_U;
                end else if (w_is_u) begin
                    // A units digit always restarts the frame
                    r_und   <= w_digit;
                    r_state <= HAVE_U;
                end else if (w_is_t && r_state == HAVE_U) begin
                    r_dez   <= w_digit;
                    r_state <= HAVE_T;
                end else if (w_frame_done) begin
                    r_state <= WAIT_U;
`ifdef DISPLAY_DEMUX_CHANGE_ONLY_EN
                    if (w_sum != r_bin) begin
                        r_bin   <= w_sum;
                        r_valid <= 1'b1;
                    end
`else
                    r_bin   <= w_sum;
                    r_valid <= 1'b1;
`endif
                end else begin
                    // Legal digit out of order: drop the partial frame silently
                    r_state <= WAIT_U;
                end
            end
        end
    end

    // Stale counter: cleared by every completed frame (even an unchanged one), else saturating count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stale_cnt <= 8'd0;
        end else if (w_frame_done) begin
            r_stale_cnt <= 8'd0;
        end else if (r_stale_cnt != c_STALE_MAX) begin
            r_stale_cnt <= r_stale_cnt + 8'd1;
        end
    end

    assign bin   = r_bin;
    assign valid = r_valid;
    assign err   = r_err;
    assign stale = (r_stale_cnt == c_STALE_MAX);

endmodule
`default_nettype wire

// File: tb/tb_display_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_demux
// Description : Directed self-checking bench for display_demux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_demux;

    localparam logic [2:0] c_U    = 3'b110;
    localparam logic [2:0] c_T    = 3'b101;
    localparam logic [2:0] c_H    = 3'b011;
    localparam logic [2:0] c_IDLE = 3'b111;

    logic       clk;
    logic       rst;
    logic [6:0] hex;
    logic [2:0] dsel;
    logic [9:0] bin;
    logic       valid;
    logic       err;
    logic       stale;

    int total;
    int bad;

    display_demux #(.STALE_CYCLES(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .hex   (hex),
        .dsel  (dsel),
        .bin   (bin),
        .valid (valid),
        .err   (err),
        .stale (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low seven-segment encodings {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b1000000;
            1: seg = 7'b1111001;
            2: seg = 7'b0100100;
            3: seg = 7'b0110000;
            4: seg = 7'b0011001;
            5: seg = 7'b0010010;
            6: seg = 7'b0000010;
            7: seg = 7'b1111000;
            8: seg = 7'b0000000;
            9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    // Drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic [6:0] h, input logic [2:0] d);
        @(negedge clk);
        hex  = h;
        dsel = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        hex   = 7'h7f;
        dsel  = c_IDLE;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_bin",   32'(bin),   32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_stale", 32'(stale), 32'd0);

        // Idle after reset: stale rises on the 8th edge
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) step(7'h7f, c_IDLE);
        chk("stale_7th", 32'(stale), 32'd0);
        step(7'h7f, c_IDLE);
        chk("stale_8th", 32'(stale), 32'd1);

        // Frame 437, stale falls on the valid edge
        step(seg(7), c_U);
        chk("437_u_valid", 32'(valid), 32'd0);
        step(seg(3), c_T);
        chk("437_t_valid", 32'(valid), 32'd0);
        step(seg(4), c_H);
        chk("437_bin",   32'(bin),   32'd437);
        chk("437_valid", 32'(valid), 32'd1);
        chk("437_err",   32'(err),   32'd0);
        chk("437_stale", 32'(stale), 32'd0);
        step(7'h7f, c_IDLE);
        chk("437_pulse_end", 32'(valid), 32'd0);
        chk("437_hold",      32'(bin),   32'd437);

        // Repeated 437 frame
        step(seg(7), c_U);
        step(seg(3), c_T);
        step(seg(4), c_H);
`ifdef DISPLAY_DEMUX_CHANGE_ONLY_EN
        chk("rep_valid", 32'(valid), 32'd0);
`else
        chk("rep_valid", 32'(valid), 32'd1);
`endif
        chk("rep_bin", 32'(bin), 32'd437);

        // Dash on units -> err, bin unchanged; then 000
        step(7'b0111111, c_U);
        chk("dash_err",   32'(err),   32'd1);
        chk("dash_valid", 32'(valid), 32'd0);
        chk("dash_bin",   32'(bin),   32'd437);
        step(seg(0), c_U);
        chk("dash_err_end", 32'(err), 32'd0);
        step(seg(0), c_T);
        step(seg(0), c_H);
        chk("000_bin",   32'(bin),   32'd0);
        chk("000_valid", 32'(valid), 32'd1);

        // Missing tens -> no valid; then 999
        step(seg(5), c_U);
        step(seg(2), c_H);
        chk("noten_valid", 32'(valid), 32'd0);
        chk("noten_err",   32'(err),   32'd0);
        chk("noten_bin",   32'(bin),   32'd0);
        step(seg(9), c_U);
        step(seg(9), c_T);
        step(seg(9), c_H);
        chk("999_bin",   32'(bin),   32'd999);
        chk("999_valid", 32'(valid), 32'd1);

        // Illegal hundreds after a good U,T: err wins, no valid
        step(seg(1), c_U);
        step(seg(2), c_T);
        step(7'b1111111, c_H);
        chk("badh_err",   32'(err),   32'd1);
        chk("badh_valid", 32'(valid), 32'd0);
        chk("badh_bin",   32'(bin),   32'd999);

        // Idle codes between digits keep the state
        step(seg(1), c_U);
        step(7'h00, c_IDLE);
        step(seg(2), c_T);
        step(7'h00, 3'b000);
        step(seg(3), c_H);
        chk("idle_bin",   32'(bin),   32'd321);
        chk("idle_valid", 32'(valid), 32'd1);

        // Reset between T and H of 123
        step(seg(3), c_U);
        step(seg(2), c_T);
        @(negedge clk);
        rst  = 1'b1;
        hex  = 7'h7f;
        dsel = c_IDLE;
        #1;
        chk("midrst_bin",   32'(bin),   32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(seg(1), c_H);
        chk("midrst_h_valid", 32'(valid), 32'd0);
        chk("midrst_h_bin",   32'(bin),   32'd0);
        step(seg(3), c_U);
        step(seg(2), c_T);
        step(seg(1), c_H);
        chk("123_bin",   32'(bin),   32'd123);
        chk("123_valid", 32'(valid), 32'd1);

        // Back-to-back frames 456 then 789
        step(seg(6), c_U);
        chk("b2b_u_valid", 32'(valid), 32'd0);
        step(seg(5), c_T);
        step(seg(4), c_H);
        chk("b2b1_bin",   32'(bin),   32'd456);
        chk("b2b1_valid", 32'(valid), 32'd1);
        step(seg(9), c_U);
        chk("b2b2_u_valid", 32'(valid), 32'd0);
        step(seg(8), c_T);
        step(seg(7), c_H);
        chk("b2b2_bin",   32'(bin),   32'd789);
        chk("b2b2_valid", 32'(valid), 32'd1);

        // Stale re-arms 8 edges after the last valid and saturates
        for (int i = 0; i < 7; i++) step(7'h7f, c_IDLE);
        chk("stale2_7th", 32'(stale), 32'd0);
        step(7'h7f, c_IDLE);
        chk("stale2_8th", 32'(stale), 32'd1);
        step(7'h7f, c_IDLE);
        chk("stale2_sat", 32'(stale), 32'd1);
        chk("stale2_bin", 32'(bin),   32'd789);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
